multicycle_mem_responder: RTL and testbench
===========================================

Name: multicycle_mem_responder

Overview:
- Unified instruction/data memory slave for the multicycle CPU.
- Sits on the memory side of the control FSM's memRead/memWrite/IorD interface.
- Accepts one word read or write at a time over a four-phase request/ready handshake.
- Inserts a configurable number of wait states, so the controller can be exercised against non-zero memory latency.

Parameters:
- DEPTH_LOG2, 8, log2 of the number of 32-bit words stored (256 words).
- WAIT_CYCLES, 2, wait states between request acceptance and the response; legal range 0..15.
- DATA_W, 32, data word width; fixed at 32, not to be overridden.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- mem_read  in  1  read request, level, held by requester until mem_ready
- mem_write  in  1  write request, level, held by requester until mem_ready
- addr  in  32  byte address; bits [DEPTH_LOG2+1:2] select the word, higher bits ignored (address aliases/wraps)
- wdata  in  32  write data
- rdata  out  32  read data; valid while mem_ready=1 after a read; held until the next completed read
- mem_ready  out  1  response/acknowledge
- mem_busy  out  1  high in WAIT and RESP
- mem_err  out  1  response carries an error; valid while mem_ready=1

Behaviour:
- Reset values: state=IDLE, rdata=0, mem_ready=0, mem_busy=0, mem_err=0, wait counter=0.
- Array contents are not cleared by reset.
- States: IDLE, WAIT, RESP, DONE.
- IDLE:
  - If mem_read|mem_write is high at a rising edge, latch addr, wdata, op and an error flag.
  - Error flag = (mem_read&mem_write) | (addr[1:0]!=0).
  - Load counter=WAIT_CYCLES. Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT: counter decrements each cycle; when counter==1, next state is RESP.
- RESP (exactly one cycle):
  - If no error and op=write: mem[idx] <= wdata_latched.
  - If no error and op=read: rdata <= mem[idx].
  - If error: no array access, rdata unchanged.
  - Set mem_ready=1, mem_err=flag. Next state DONE.
- DONE:
  - mem_ready and mem_err are held.
  - When mem_read and mem_write are both low: clear mem_ready and mem_err, go to IDLE.
  - A new request is accepted no earlier than the cycle after the return to IDLE.
- Latency: request sampled at edge N gives mem_ready=1 from edge N+WAIT_CYCLES+1.
- Input changes while busy: changes to addr/wdata/op during WAIT/RESP/DONE are ignored, because the latched copies are used.
- Request dropped early: if the request is deasserted before mem_ready, the transaction still completes. The write still commits, and mem_ready pulses for at least 1 cycle in DONE.
- Back-to-back: the requester must deassert for at least 1 cycle between transactions. A request held high through DONE keeps the block in DONE; no double access occurs.
- Reset mid-operation: state returns to IDLE. A pending write in WAIT is discarded and the array is unchanged. A write committed in RESP stays committed.
- Read-after-write to the same address returns the new data.
- rdata is registered; there is no combinational path from addr to rdata.

Test Plan:
- Basic write then read (WAIT_CYCLES=2): write 0xDEADBEEF at addr 0x10, then read 0x10 → mem_ready rises 3 cycles after each request; rdata=0xDEADBEEF; mem_err=0.
- Zero-wait config (WAIT_CYCLES=0): write 0x12345678 at addr 0x04, then read it back → mem_ready 1 cycle after request; rdata=0x12345678.
- Errors:
  - Read at addr 0x13 → mem_ready with mem_err=1; rdata keeps its previous value.
  - Both read and write high with addr 0x20 and wdata 0xFFFFFFFF → mem_err=1; a later read of 0x20 returns the old contents.
- Aliasing: write 0xA5A5A5A5 at addr 0x400 (DEPTH_LOG2=8), then read addr 0x000 → 0xA5A5A5A5.
- Handshake hold: keep mem_read high for 10 cycles after mem_ready → mem_ready stays 1 with no second access. Drop mem_read → mem_ready=0 next cycle, state IDLE.
- Reset mid-write: write 0x55 at addr 0x08 and assert reset during WAIT → outputs return to reset values; a subsequent read of 0x08 returns the prior value (pre-written 0x11).

Source files
------------

// File: rtl/multicycle_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_mem_responder: unified I/D word memory with fixed wait states  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module multicycle_mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_err
);

    localparam int         C_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] C_WAIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_write;
    logic                  r_err;
    logic [DATA_W-1:0]     r_mem [C_DEPTH];

    logic w_req;
    logic w_accept;
    logic w_resp;
    logic w_release;
    logic w_unused_addr;

    assign w_req         = mem_read | mem_write;
    assign mem_busy      = (r_state == S_WAIT) || (r_state == S_RESP);
    // Upper address bits alias onto the array and are deliberately dropped.
    assign w_unused_addr = ^addr[31:DEPTH_LOG2+2];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_resp       = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = C_WAIT;
                    w_state_next = (C_WAIT == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                w_resp       = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                // Stay here while the requester still holds its request.
                if (!w_req) begin
                    w_release    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            rdata     <= '0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_idx   <= addr[DEPTH_LOG2+1:2];
                r_wdata <= wdata;
                r_write <= mem_write;
                r_err   <= (mem_read & mem_write) | (addr[1:0] != 2'b00);
            end
            if (w_resp) begin
                mem_ready <= 1'b1;
                mem_err   <= r_err;
                if (!r_err && !r_write) begin
                    rdata <= r_mem[r_idx];
                end
            end
            if (w_release) begin
                mem_ready <= 1'b0;
                mem_err   <= 1'b0;
            end
        end
    end

    // Array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_resp && !r_err && r_write) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_mem_responder.sv
`default_nettype none
// Testbench for multicycle_mem_responder: one instance with two wait states
// and one with zero, checked against a word-array model via a scoreboard.
module tb_multicycle_mem_responder;

    localparam int WAIT_A = 2;
    localparam int WAIT_B = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_a = 0, wr_a = 0, rd_b = 0, wr_b = 0;
    logic [31:0] addr_a = 0, wdata_a = 0, addr_b = 0, wdata_b = 0;
    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, busy_a, err_a, ready_b, busy_b, err_b;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [31:0] model [256];
    logic [31:0] last_rdata [2];

    always #5 clk = ~clk;

    multicycle_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(WAIT_A), .DATA_W(32)) dut_a (
        .clk(clk), .reset(reset), .mem_read(rd_a), .mem_write(wr_a), .addr(addr_a),
        .wdata(wdata_a), .rdata(rdata_a), .mem_ready(ready_a), .mem_busy(busy_a), .mem_err(err_a)
    );

    multicycle_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(WAIT_B), .DATA_W(32)) dut_b (
        .clk(clk), .reset(reset), .mem_read(rd_b), .mem_write(wr_b), .addr(addr_b),
        .wdata(wdata_b), .rdata(rdata_b), .mem_ready(ready_b), .mem_busy(busy_b), .mem_err(err_b)
    );

    function automatic logic rdy(input bit sel);
        return sel ? ready_b : ready_a;
    endfunction

    function automatic logic bsy(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            rd_b = rd; wr_b = wr; addr_b = a; wdata_b = d;
        end else begin
            rd_a = rd; wr_a = wr; addr_a = a; wdata_a = d;
        end
    endtask

    // One complete transaction; inputs are scrambled once the request is accepted.
    task automatic txn(input bit sel, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input int hold, input bit drop);
        exp_t        e;
        logic [7:0]  idx;
        int          lat;
        int          wait_cfg;
        logic [31:0] got_rdata;
        logic        got_err;
        idx      = a[9:2];
        wait_cfg = sel ? WAIT_B : WAIT_A;
        e.err    = (rd & wr) | (a[1:0] != 2'b00);
        if (!e.err && wr) model[idx] = d;
        e.rdata = (!e.err && rd) ? model[idx] : last_rdata[sel];
        sb.push_back(e);

        @(negedge clk);
        drive(sel, rd, wr, a, d);
        @(posedge clk); #1;
        checks++;
        if (bsy(sel) !== 1'b1) begin
            errors++; $display("FAIL busy_after_accept: got %b expected 1", bsy(sel));
        end
        if (drop) drive(sel, 1'b0, 1'b0, ~a, ~d);
        else      drive(sel, rd, wr, ~a, ~d);

        lat = 0;
        while (rdy(sel) !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        checks++;
        if (rdy(sel) !== 1'b1) begin
            errors++; $display("FAIL ready_timeout: got no mem_ready within %0d cycles", lat);
        end else begin
            got_rdata = sel ? rdata_b : rdata_a;
            got_err   = sel ? err_b : err_a;
            if (lat !== wait_cfg + 1) begin
                errors++; $display("FAIL latency: got %0d expected %0d", lat, wait_cfg + 1);
            end
            checks++;
            if (got_rdata !== e.rdata) begin
                errors++; $display("FAIL rdata @%h: got %h expected %h", a, got_rdata, e.rdata);
            end
            checks++;
            if (got_err !== e.err) begin
                errors++; $display("FAIL mem_err @%h: got %b expected %b", a, got_err, e.err);
            end
        end
        last_rdata[sel] = e.rdata;

        if (!drop) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                checks++;
                if (rdy(sel) !== 1'b1 || bsy(sel) !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_cycle%0d: got ready=%b busy=%b expected ready=1 busy=0",
                             i, rdy(sel), bsy(sel));
                end
            end
        end

        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        checks++;
        if (rdy(sel) !== 1'b0 || (sel ? err_b : err_a) !== 1'b0) begin
            errors++; $display("FAIL release: got ready=%b err=%b expected 0 0",
                               rdy(sel), sel ? err_b : err_a);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ready_a, busy_a, err_a, ready_b, busy_b, err_b} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000",
                               {ready_a, busy_a, err_a, ready_b, busy_b, err_b});
        end
        checks++;
        if (rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h/%h expected 0", rdata_a, rdata_b);
        end
        @(negedge clk);
        reset = 1'b0;
        last_rdata[0] = 32'h0;
        last_rdata[1] = 32'h0;
    endtask

    task automatic test_basic();
        txn(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0);
        txn(0, 1, 0, 32'h10, 32'h0, 0, 0);
    endtask

    task automatic test_zero_wait();
        txn(1, 0, 1, 32'h04, 32'h12345678, 0, 0);
        txn(1, 1, 0, 32'h04, 32'h0, 0, 0);
    endtask

    task automatic test_errors();
        txn(0, 1, 0, 32'h13, 32'h0, 0, 0);
        txn(0, 0, 1, 32'h20, 32'hCAFEF00D, 0, 0);
        txn(0, 1, 1, 32'h20, 32'hFFFFFFFF, 0, 0);
        txn(0, 1, 0, 32'h20, 32'h0, 0, 0);
        txn(1, 0, 1, 32'h0A, 32'h99999999, 0, 0);
    endtask

    task automatic test_alias();
        txn(0, 0, 1, 32'h400, 32'hA5A5A5A5, 0, 0);
        txn(0, 1, 0, 32'h000, 32'h0, 0, 0);
        txn(1, 0, 1, 32'hFFFF_F3FC, 32'h0BADF00D, 0, 0);
        txn(1, 1, 0, 32'h0000_03FC, 32'h0, 0, 0);
    endtask

    task automatic test_hold();
        txn(0, 1, 0, 32'h000, 32'h0, 10, 0);
        txn(0, 0, 1, 32'h44, 32'h13572468, 3, 0);
        txn(0, 1, 0, 32'h44, 32'h0, 0, 0);
    endtask

    task automatic test_early_drop();
        txn(0, 0, 1, 32'h30, 32'h00000077, 0, 1);
        txn(0, 1, 0, 32'h30, 32'h0, 0, 1);
        txn(1, 0, 1, 32'h34, 32'h89ABCDEF, 0, 1);
        txn(1, 1, 0, 32'h34, 32'h0, 0, 0);
    endtask

    task automatic test_reset_mid_write();
        txn(0, 0, 1, 32'h08, 32'h00000011, 0, 0);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h08, 32'h00000055);
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        checks++;
        if ({ready_a, busy_a, err_a} !== 3'b000 || rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
            errors++; $display("FAIL mid_reset_outputs: got r=%b b=%b e=%b rdata=%h/%h expected 0",
                               ready_a, busy_a, err_a, rdata_a, rdata_b);
        end
        @(negedge clk);
        reset = 1'b0;
        last_rdata[0] = 32'h0;
        last_rdata[1] = 32'h0;
        txn(0, 1, 0, 32'h08, 32'h0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_wait();
        test_errors();
        test_alias();
        test_hold();
        test_early_drop();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
